// File: rtl/alu_pkg.sv
// Shared ALU definitions: legal op codes, legality check, sequencer FSM states.
`timescale 1ns/1ps
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SHL   = 4'b0011,
    ALU_SHR   = 4'b0100,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // The ALU leaves BusW stale for anything outside this list.
  function automatic logic alu_op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SHL,
      ALU_SHR, ALU_SUB, ALU_PASSB: ok = 1'b1;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr_i, wrapping.
`timescale 1ns/1ps
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && valid_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one external combinational ALU among NREQ requesters, round-robin,
// one operation in flight, response tagged with the owning requester ID.
`timescale 1ns/1ps
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              Resetb,
  input  logic [NREQ-1:0]   ReqValid,
  output logic [NREQ-1:0]   ReqReady,
  input  logic [NREQ*DW-1:0] ReqA,
  input  logic [NREQ*DW-1:0] ReqB,
  input  logic [NREQ*4-1:0] ReqOp,
  output logic [DW-1:0]     BusA,
  output logic [DW-1:0]     BusB,
  output logic [3:0]        ALUCtrl,
  input  logic [DW-1:0]     BusW,
  input  logic              Zero,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [IDW-1:0]    RspId,
  output logic [DW-1:0]     RspData,
  output logic              RspZero,
  output logic              RspErr,
  output logic              Busy
);

  seq_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, win_idx;
  logic [NREQ-1:0] gnt;
  logic [DW-1:0]  bus_a_q, bus_b_q, rsp_data_q;
  logic [3:0]     ctrl_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_zero_q, rsp_err_q;
  logic [DW-1:0]  win_a, win_b;
  logic [3:0]     win_op;
  logic           accept, win_legal;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (ReqValid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx)
  );

  // One-hot AND-OR mux of the winner's fields.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_a  = win_a  | ReqA[i*DW +: DW];
        win_b  = win_b  | ReqB[i*DW +: DW];
        win_op = win_op | ReqOp[i*4 +: 4];
      end
    end
  end

  assign win_legal = alu_op_legal(win_op);
  assign accept    = (state_q == IDLE) && (|ReqValid);

  always_comb begin
    state_d  = state_q;
    ReqReady = '0;
    case (state_q)
      IDLE: begin
        ReqReady = gnt;
        if (accept) state_d = win_legal ? EXEC : RESP;
      end
      EXEC:    state_d = RESP;
      RESP:    if (RspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      id_q       <= '0;
      bus_a_q    <= '0;
      bus_b_q    <= '0;
      ctrl_q     <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= win_idx;
        id_q  <= win_idx;
        if (win_legal) begin
          bus_a_q <= win_a;
          bus_b_q <= win_b;
          ctrl_q  <= win_op;
        end else begin
          // Illegal op never reaches the ALU; answer directly with an error.
          rsp_err_q  <= 1'b1;
          rsp_data_q <= '0;
          rsp_zero_q <= 1'b0;
          rsp_id_q   <= win_idx;
        end
      end
      if (state_q == EXEC) begin
        rsp_data_q <= BusW;
        rsp_zero_q <= Zero;
        rsp_err_q  <= 1'b0;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign BusA     = bus_a_q;
  assign BusB     = bus_b_q;
  assign ALUCtrl  = ctrl_q;
  assign RspValid = (state_q == RESP);
  assign RspId    = rsp_id_q;
  assign RspData  = rsp_data_q;
  assign RspZero  = rsp_zero_q;
  assign RspErr   = rsp_err_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed self-checking bench for alu_rr_sequencer with a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_rr_sequencer;

  logic         CLK;
  logic         Resetb;
  logic [3:0]   ReqValid;
  logic [3:0]   ReqReady;
  logic [255:0] ReqA, ReqB;
  logic [15:0]  ReqOp;
  logic [63:0]  BusA, BusB, BusW;
  logic [3:0]   ALUCtrl;
  logic         Zero;
  logic         RspValid, RspReady;
  logic [1:0]   RspId;
  logic [63:0]  RspData;
  logic         RspZero, RspErr, Busy;

  logic [63:0]  a_arr [4];
  logic [63:0]  b_arr [4];
  logic [3:0]   op_arr [4];

  int checks = 0;
  int errors = 0;

  assign ReqA  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign ReqB  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
  assign ReqOp = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a << b;
      4'b0100: return a >> b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  assign BusW = alu_f(BusA, BusB, ALUCtrl);
  assign Zero = (BusW == 64'd0);

  alu_rr_sequencer #(.NREQ(4), .DW(64), .IDW(2)) dut (
    .CLK      (CLK),
    .Resetb   (Resetb),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqOp    (ReqOp),
    .BusA     (BusA),
    .BusB     (BusB),
    .ALUCtrl  (ALUCtrl),
    .BusW     (BusW),
    .Zero     (Zero),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspId    (RspId),
    .RspData  (RspData),
    .RspZero  (RspZero),
    .RspErr   (RspErr),
    .Busy     (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b);
    op_arr[i] = op;
    a_arr[i]  = a;
    b_arr[i]  = b;
  endtask

  task automatic test_reset();
    Resetb = 1'b0; ReqValid = 4'b0; RspReady = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({ReqReady, ALUCtrl, RspValid, RspId, RspZero, RspErr, Busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b ctrl=%b vld=%b id=%0d z=%b err=%b busy=%b, want all 0",
               ReqReady, ALUCtrl, RspValid, RspId, RspZero, RspErr, Busy);
    end
    checks++;
    if ({BusA, BusB, RspData} !== 192'd0) begin
      errors++;
      $display("FAIL reset_data: got A=%h B=%h D=%h, want 0", BusA, BusB, RspData);
    end
    Resetb = 1'b1;
    set_req(0, 4'b0010, 64'd5, 64'd7);
    ReqValid = 4'b0001;
    #1;
    checks++;
    if (ReqReady !== 4'b0001) begin
      errors++; $display("FAIL first_rdy: got %b want 0001", ReqReady);
    end
    cyc();
    ReqValid = 4'b0;
    checks++;
    if ({Busy, ReqReady, RspValid} !== 6'b1_0000_0 || BusA !== 64'd5 || BusB !== 64'd7 ||
        ALUCtrl !== 4'b0010) begin
      errors++;
      $display("FAIL first_exec: got busy=%b rdy=%b vld=%b A=%0d B=%0d ctrl=%b, want 1 0000 0 5 7 0010",
               Busy, ReqReady, RspValid, BusA, BusB, ALUCtrl);
    end
    cyc();
    checks++;
    if (RspValid !== 1'b1 || RspData !== 64'd12 || RspZero !== 1'b0 || RspId !== 2'd0 ||
        RspErr !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp: got vld=%b d=%0d z=%b id=%0d err=%b, want 1 12 0 0 0",
               RspValid, RspData, RspZero, RspId, RspErr);
    end
    RspReady = 1'b1;
    cyc();
    checks++;
    if (RspValid !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL first_done: got vld=%b busy=%b want 0 0", RspValid, Busy);
    end
  endtask

  task automatic test_sub_zero();
    set_req(2, 4'b0110, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    ReqValid = 4'b0100;
    #1;
    checks++;
    if (ReqReady !== 4'b0100) begin
      errors++; $display("FAIL sub_rdy: got %b want 0100", ReqReady);
    end
    cyc();
    ReqValid = 4'b0;
    cyc();
    checks++;
    if (RspValid !== 1'b1 || RspData !== 64'd0 || RspZero !== 1'b1 || RspId !== 2'd2) begin
      errors++;
      $display("FAIL sub_rsp: got vld=%b d=%h z=%b id=%0d, want 1 0 1 2",
               RspValid, RspData, RspZero, RspId);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_d [4];
    logic        exp_z [4];
    int r;
    exp_d[0] = 64'd3;  exp_d[1] = 64'hFF; exp_d[2] = 64'd0;
    exp_d[3] = 64'h8000_0000_0000_0000;
    exp_z[0] = 1'b0;   exp_z[1] = 1'b0;   exp_z[2] = 1'b1; exp_z[3] = 1'b0;
    Resetb = 1'b0;
    cyc();
    Resetb = 1'b1;
    set_req(0, 4'b0010, 64'd1, 64'd2);
    set_req(1, 4'b0001, 64'hF0, 64'h0F);
    set_req(2, 4'b0011, 64'd1, 64'd64);
    set_req(3, 4'b0111, 64'd9, 64'h8000_0000_0000_0000);
    RspReady = 1'b1;
    ReqValid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      r = n % 4;
      checks++;
      if (ReqReady !== (4'b0001 << r)) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", n, ReqReady, 4'b0001 << r);
      end
      cyc();
      checks++;
      if (ReqReady !== 4'b0000 || Busy !== 1'b1) begin
        errors++; $display("FAIL rr_exec%0d: got rdy=%b busy=%b want 0000 1", n, ReqReady, Busy);
      end
      cyc();
      checks++;
      if (RspValid !== 1'b1 || RspId !== 2'(r) || RspData !== exp_d[r] || RspZero !== exp_z[r]) begin
        errors++;
        $display("FAIL rr_rsp%0d: got vld=%b id=%0d d=%h z=%b want 1 %0d %h %b",
                 n, RspValid, RspId, RspData, RspZero, r, exp_d[r], exp_z[r]);
      end
      cyc();
    end
    ReqValid = 4'b0;
  endtask

  task automatic test_illegal();
    set_req(1, 4'b0101, 64'h55, 64'hAA);
    ReqValid = 4'b0010;
    #1;
    checks++;
    if (ReqReady !== 4'b0010) begin
      errors++; $display("FAIL ill_rdy: got %b want 0010", ReqReady);
    end
    cyc();
    ReqValid = 4'b0;
    checks++;
    if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspData !== 64'd0 || RspZero !== 1'b0 ||
        RspId !== 2'd1) begin
      errors++;
      $display("FAIL ill_rsp: got vld=%b err=%b d=%h z=%b id=%0d want 1 1 0 0 1",
               RspValid, RspErr, RspData, RspZero, RspId);
    end
    checks++;
    if (ALUCtrl !== 4'b0010 || BusA !== 64'd1 || BusB !== 64'd2) begin
      errors++;
      $display("FAIL ill_bus: got ctrl=%b A=%h B=%h want 0010 1 2", ALUCtrl, BusA, BusB);
    end
    cyc();
    set_req(1, 4'b1010, 64'h3, 64'h4);
    ReqValid = 4'b0010;
    cyc();
    ReqValid = 4'b0;
    checks++;
    if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspId !== 2'd1 || ALUCtrl !== 4'b0010) begin
      errors++;
      $display("FAIL ill_hi: got vld=%b err=%b id=%0d ctrl=%b want 1 1 1 0010",
               RspValid, RspErr, RspId, ALUCtrl);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    RspReady = 1'b0;
    set_req(3, 4'b0000, 64'hFF00, 64'h0FF0);
    ReqValid = 4'b1000;
    #1;
    checks++;
    if (ReqReady !== 4'b1000) begin
      errors++; $display("FAIL bp_rdy: got %b want 1000", ReqReady);
    end
    cyc();
    ReqValid = 4'b1111;
    set_req(3, 4'b0010, 64'd1, 64'd1);
    cyc();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (RspValid !== 1'b1 || RspData !== 64'h0F00 || RspId !== 2'd3 || RspErr !== 1'b0 ||
          ReqReady !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b d=%h id=%0d err=%b rdy=%b want 1 f00 3 0 0000",
                 n, RspValid, RspData, RspId, RspErr, ReqReady);
      end
      cyc();
    end
    RspReady = 1'b1;
    #1;
    checks++;
    if (RspValid !== 1'b1 || ReqReady !== 4'b0000) begin
      errors++; $display("FAIL bp_release: got vld=%b rdy=%b want 1 0000", RspValid, ReqReady);
    end
    cyc();
    checks++;
    if (ReqReady !== 4'b0001) begin
      errors++; $display("FAIL bp_resume: got %b want 0001", ReqReady);
    end
    ReqValid = 4'b0;
    #1;
    cyc();
    checks++;
    if (Busy !== 1'b0 || ReqReady !== 4'b0000) begin
      errors++; $display("FAIL bp_drop: got busy=%b rdy=%b want 0 0000", Busy, ReqReady);
    end
  endtask

  task automatic test_back_to_back();
    set_req(2, 4'b0111, 64'd0, 64'h1234);
    ReqValid = 4'b0100;
    #1;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (ReqReady !== 4'b0100) begin
        errors++; $display("FAIL b2b_rdy%0d: got %b want 0100", n, ReqReady);
      end
      cyc();
      cyc();
      checks++;
      if (RspValid !== 1'b1 || RspData !== 64'h1234 || RspId !== 2'd2) begin
        errors++;
        $display("FAIL b2b_rsp%0d: got vld=%b d=%h id=%0d want 1 1234 2", n, RspValid, RspData, RspId);
      end
      cyc();
    end
    ReqValid = 4'b0;
  endtask

  task automatic test_reset_mid();
    set_req(1, 4'b0010, 64'd10, 64'd20);
    ReqValid = 4'b0010;
    cyc();
    ReqValid = 4'b0;
    checks++;
    if (Busy !== 1'b1 || RspValid !== 1'b0) begin
      errors++; $display("FAIL mid_exec: got busy=%b vld=%b want 1 0", Busy, RspValid);
    end
    Resetb = 1'b0;
    #1;
    checks++;
    if (RspValid !== 1'b0 || Busy !== 1'b0 || BusA !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b busy=%b A=%h want 0 0 0", RspValid, Busy, BusA);
    end
    cyc();
    checks++;
    if (RspValid !== 1'b0) begin
      errors++; $display("FAIL mid_hold: got vld=%b want 0", RspValid);
    end
    Resetb = 1'b1;
    set_req(0, 4'b0010, 64'd1, 64'd1);
    set_req(3, 4'b0010, 64'd2, 64'd2);
    ReqValid = 4'b1001;
    #1;
    checks++;
    if (ReqReady !== 4'b0001) begin
      errors++; $display("FAIL mid_ptr: got %b want 0001", ReqReady);
    end
    ReqValid = 4'b0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) set_req(i, 4'b0000, 64'd0, 64'd0);
    test_reset();
    test_sub_zero();
    test_round_robin();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
